// File: rtl/cpuex_pkg.sv
// Shared types and constants for the program loader: state/status codes,
// send-handshake phases, UART byte type and the header range check.
package cpuex_pkg;

   typedef logic [7:0] uart_byte_t;

   localparam logic [2:0] STATUS_IDLE = 3'b000;
   localparam logic [2:0] STATUS_HDR  = 3'b001;
   localparam logic [2:0] STATUS_DATA = 3'b010;
   localparam logic [2:0] STATUS_ACK  = 3'b011;
   localparam logic [2:0] STATUS_RUN  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b000,
      ST_HDR  = 3'b001,
      ST_DATA = 3'b010,
      ST_ACK  = 3'b011,
      ST_RUN  = 3'b100
   } loader_state_t;

   typedef enum logic [1:0] {
      SND_WAIT_RDY  = 2'b00,
      SND_WAIT_LOW  = 2'b01,
      SND_WAIT_HIGH = 2'b10,
      SND_PC_RESET  = 2'b11
   } send_phase_t;

   localparam uart_byte_t DEF_ACK_BYTE = 8'hAA;
   localparam uart_byte_t DEF_NAK_BYTE = 8'h55;

   // A header is usable when it names at least one word and fits the memory.
   function automatic logic hdr_ok(input logic [31:0] n, input logic [31:0] cap);
      return (n != 32'd0) && (n <= cap);
   endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Collects four strobed bytes little-endian into a 32-bit word and emits it
// with a one-cycle valid; a synchronous clear drops any partial word.
module uart_word_assembler
   import cpuex_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_valid,
   input  uart_byte_t  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [1:0]  r_cnt;
   logic [23:0] r_low;
   logic [31:0] r_word;
   logic        r_valid;

   // Byte collection; the finished word lives in its own register so a byte
   // arriving during the valid cycle cannot corrupt it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= 2'd0;
         r_low   <= 24'd0;
         r_word  <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_cnt   <= 2'd0;
         r_low   <= 24'd0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_valid) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
               2'd0:    r_low[7:0]   <= i_byte;
               2'd1:    r_low[15:8]  <= i_byte;
               2'd2:    r_low[23:16] <= i_byte;
               default: begin
                  r_word  <= {i_byte, r_low};
                  r_low   <= 24'd0;
                  r_valid <= 1'b1;
               end
            endcase
         end
      end
   end

   assign o_word       = r_word;
   assign o_word_valid = r_valid;

endmodule

// File: rtl/program_loader_ctrl.sv
// Start-up sequencer: loads a counted program image from UART into
// instruction memory, acknowledges it, then hands the UART to the core.
module program_loader_ctrl
   import cpuex_pkg::*;
#(
   parameter int         INST_MEM_WIDTH = 10,
   parameter uart_byte_t ACK_BYTE       = DEF_ACK_BYTE,
   parameter uart_byte_t NAK_BYTE       = DEF_NAK_BYTE
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_abort,
   input  uart_byte_t                i_rx_data,
   input  logic                      i_rx_valid,
   input  logic                      i_tx_ready,
   output uart_byte_t                o_tx_data,
   output logic                      o_tx_enable,
   output uart_byte_t                o_core_rx_data,
   output logic                      o_core_rx_valid,
   input  uart_byte_t                i_core_tx_data,
   input  logic                      i_core_tx_enable,
   output logic                      o_core_tx_ready,
   output logic                      o_imem_we,
   output logic [INST_MEM_WIDTH-1:0] o_imem_addr,
   output logic [31:0]               o_imem_wdata,
   output logic                      o_core_run,
   output logic                      o_core_pc_reset,
   output logic [2:0]                o_status,
   output logic                      o_error
);

   localparam int              CW       = INST_MEM_WIDTH + 1;
   localparam logic [CW-1:0]   ONE_C    = CW'(1);
   localparam logic [31:0]     CAPACITY = 32'(2 ** INST_MEM_WIDTH);

   loader_state_t r_state, nxt_state;
   send_phase_t   r_phase, nxt_phase;
   logic          r_nak, nxt_nak;
   logic [CW-1:0] r_count, nxt_count;
   logic [CW-1:0] r_widx, nxt_widx;
   logic          r_err, nxt_err;
   logic          r_tx_en, nxt_tx_en;
   uart_byte_t    r_tx_data, nxt_tx_data;
   logic          r_pc_reset, nxt_pc_reset;
   logic          r_core_run;

   logic          w_asm_clear;
   logic          w_asm_valid;
   logic [31:0]   w_word;
   logic          w_word_valid;
   logic          w_start_ok;
   logic          w_run;

   uart_word_assembler u_asm (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (w_asm_clear),
      .i_valid      (w_asm_valid),
      .i_byte       (i_rx_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // State and loader-output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_phase    <= SND_WAIT_RDY;
         r_nak      <= 1'b0;
         r_count    <= '0;
         r_widx     <= '0;
         r_err      <= 1'b0;
         r_tx_en    <= 1'b0;
         r_tx_data  <= 8'h00;
         r_pc_reset <= 1'b0;
         r_core_run <= 1'b0;
      end else begin
         r_state    <= nxt_state;
         r_phase    <= nxt_phase;
         r_nak      <= nxt_nak;
         r_count    <= nxt_count;
         r_widx     <= nxt_widx;
         r_err      <= nxt_err;
         r_tx_en    <= nxt_tx_en;
         r_tx_data  <= nxt_tx_data;
         r_pc_reset <= nxt_pc_reset;
         r_core_run <= (nxt_state == ST_RUN);
      end
   end

   // Next-state logic: abort beats start, start beats normal progress.
   always_comb begin
      nxt_state    = r_state;
      nxt_phase    = r_phase;
      nxt_nak      = r_nak;
      nxt_count    = r_count;
      nxt_widx     = r_widx;
      nxt_err      = r_err;
      nxt_tx_en    = 1'b0;
      nxt_tx_data  = 8'h00;
      nxt_pc_reset = 1'b0;
      w_asm_clear  = 1'b0;
      w_start_ok   = i_start && ((r_state == ST_IDLE) || (r_state == ST_ACK) ||
                                 (r_state == ST_RUN));
      w_asm_valid  = i_rx_valid && ((r_state == ST_HDR) || (r_state == ST_DATA));

      if (i_abort) begin
         nxt_state   = ST_IDLE;
         w_asm_clear = 1'b1;
      end else if (w_start_ok) begin
         nxt_state   = ST_HDR;
         nxt_err     = 1'b0;
         nxt_count   = '0;
         nxt_widx    = '0;
         w_asm_clear = 1'b1;
      end else begin
         case (r_state)
            ST_HDR: begin
               if (w_word_valid) begin
                  if (hdr_ok(w_word, CAPACITY)) begin
                     nxt_state = ST_DATA;
                     nxt_count = w_word[CW-1:0];
                  end else begin
                     nxt_state   = ST_ACK;
                     nxt_phase   = SND_WAIT_RDY;
                     nxt_nak     = 1'b1;
                     nxt_err     = 1'b1;
                     w_asm_clear = 1'b1;
                  end
               end else begin
                  nxt_state = ST_HDR;
               end
            end
            ST_DATA: begin
               if (w_word_valid) begin
                  nxt_widx = r_widx + ONE_C;
                  if (r_widx == (r_count - ONE_C)) begin
                     nxt_state   = ST_ACK;
                     nxt_phase   = SND_WAIT_RDY;
                     nxt_nak     = 1'b0;
                     w_asm_clear = 1'b1;
                  end else begin
                     nxt_state = ST_DATA;
                  end
               end else begin
                  nxt_state = ST_DATA;
               end
            end
            ST_ACK: begin
               w_asm_clear = 1'b1;
               case (r_phase)
                  SND_WAIT_RDY: begin
                     if (i_tx_ready) begin
                        nxt_tx_en   = 1'b1;
                        nxt_tx_data = r_nak ? NAK_BYTE : ACK_BYTE;
                        nxt_phase   = SND_WAIT_LOW;
                     end else begin
                        nxt_phase = SND_WAIT_RDY;
                     end
                  end
                  SND_WAIT_LOW: begin
                     if (!i_tx_ready) begin
                        nxt_phase = SND_WAIT_HIGH;
                     end else begin
                        nxt_phase = SND_WAIT_LOW;
                     end
                  end
                  SND_WAIT_HIGH: begin
                     if (i_tx_ready && r_nak) begin
                        nxt_state = ST_IDLE;
                     end else if (i_tx_ready) begin
                        nxt_pc_reset = 1'b1;
                        nxt_phase    = SND_PC_RESET;
                     end else begin
                        nxt_phase = SND_WAIT_HIGH;
                     end
                  end
                  default: nxt_state = ST_RUN;
               endcase
            end
            ST_IDLE: w_asm_clear = 1'b1;
            ST_RUN:  w_asm_clear = 1'b1;
            default: begin
               nxt_state   = ST_IDLE;
               w_asm_clear = 1'b1;
            end
         endcase
      end
   end

   // UART ownership follows the run state; outside RUN the core sees nothing.
   assign w_run           = (r_state == ST_RUN);
   assign o_core_rx_data  = w_run ? i_rx_data : 8'h00;
   assign o_core_rx_valid = w_run & i_rx_valid;
   assign o_core_tx_ready = w_run & i_tx_ready;
   assign o_tx_data       = w_run ? i_core_tx_data : r_tx_data;
   assign o_tx_enable     = w_run ? i_core_tx_enable : r_tx_en;

   assign o_imem_we       = w_word_valid && (r_state == ST_DATA);
   assign o_imem_addr     = r_widx[INST_MEM_WIDTH-1:0];
   assign o_imem_wdata    = w_word;
   assign o_core_run      = r_core_run;
   assign o_core_pc_reset = r_pc_reset;
   assign o_status        = r_state;
   assign o_error         = r_err;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed self-checking bench for program_loader_ctrl: upload, NAK, abort,
// restart, reset mid-load and a table of UART-arbitration vectors.
module tb_program_loader_ctrl;
   import cpuex_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0, i_abort = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        i_tx_ready = 1'b1;
   logic [7:0]  o_tx_data;
   logic        o_tx_enable;
   logic [7:0]  o_core_rx_data;
   logic        o_core_rx_valid;
   logic [7:0]  i_core_tx_data = 8'h00;
   logic        i_core_tx_enable = 1'b0;
   logic        o_core_tx_ready;
   logic        o_imem_we;
   logic [9:0]  o_imem_addr;
   logic [31:0] o_imem_wdata;
   logic        o_core_run, o_core_pc_reset, o_error;
   logic [2:0]  o_status;

   int n_cmp = 0;
   int n_fail = 0;
   int tx_pulses = 0;
   int pcr_pulses = 0;
   logic [9:0]  log_addr[$];
   logic [31:0] log_data[$];

   typedef struct {
      logic [7:0] rx_data; logic rx_valid; logic [7:0] ctx_data; logic ctx_en; logic tx_rdy;
      logic [7:0] e_crx_data; logic e_crx_valid; logic [7:0] e_tx_data; logic e_tx_en; logic e_ctx_rdy;
   } vec_t;
   vec_t run_vecs[4];
   vec_t idle_vecs[2];

   program_loader_ctrl #(.INST_MEM_WIDTH(10)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_tx_ready(i_tx_ready),
      .o_tx_data(o_tx_data), .o_tx_enable(o_tx_enable),
      .o_core_rx_data(o_core_rx_data), .o_core_rx_valid(o_core_rx_valid),
      .i_core_tx_data(i_core_tx_data), .i_core_tx_enable(i_core_tx_enable),
      .o_core_tx_ready(o_core_tx_ready), .o_imem_we(o_imem_we),
      .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
      .o_core_run(o_core_run), .o_core_pc_reset(o_core_pc_reset),
      .o_status(o_status), .o_error(o_error)
   );

   always #5 clk = ~clk;

   // Mid-cycle monitor of memory writes, loader sends and pc-reset pulses.
   always @(negedge clk) begin
      if (o_imem_we) begin
         log_addr.push_back(o_imem_addr);
         log_data.push_back(o_imem_wdata);
      end
      if (o_tx_enable && o_status != 3'b100) tx_pulses = tx_pulses + 1;
      if (o_core_pc_reset) pcr_pulses = pcr_pulses + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Plays the sender: waits for a loader send, checks the byte, then goes busy and idle again.
   task automatic handle_tx(input logic [7:0] exp_byte, input string name);
      logic seen = 1'b0;
      logic [7:0] got = 8'h00;
      for (int i = 0; i < 50 && !seen; i++) begin
         tick();
         if (o_tx_enable) begin
            seen = 1'b1;
            got = o_tx_data;
         end
      end
      check({name, "_seen"}, {31'd0, seen}, 32'd1);
      check({name, "_byte"}, {24'd0, got}, {24'd0, exp_byte});
      i_tx_ready = 1'b0;
      tick();
      tick();
      i_tx_ready = 1'b1;
      tick();
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      i_rx_data = v.rx_data;
      i_rx_valid = v.rx_valid;
      i_core_tx_data = v.ctx_data;
      i_core_tx_enable = v.ctx_en;
      i_tx_ready = v.tx_rdy;
      #1;
      check({name, "_crx"}, {23'd0, o_core_rx_valid, o_core_rx_data}, {23'd0, v.e_crx_valid, v.e_crx_data});
      check({name, "_tx"}, {22'd0, o_core_tx_ready, o_tx_enable, o_tx_data},
            {22'd0, v.e_ctx_rdy, v.e_tx_en, v.e_tx_data});
      tick();
   endtask

   initial begin
      int base;
      int txb;
      run_vecs[0] = '{8'h41, 1'b1, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1, 8'h00, 1'b0, 1'b1};
      run_vecs[1] = '{8'h00, 1'b0, 8'h42, 1'b1, 1'b1, 8'h00, 1'b0, 8'h42, 1'b1, 1'b1};
      run_vecs[2] = '{8'h7F, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h7F, 1'b1, 8'hC3, 1'b1, 1'b0};
      run_vecs[3] = '{8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0};
      idle_vecs[0] = '{8'h41, 1'b1, 8'h42, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      idle_vecs[1] = '{8'hFF, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

      // Reset state.
      #12;
      check("rst_outs", {o_tx_data, o_tx_enable, o_core_rx_valid, o_core_tx_ready, o_imem_we,
                         o_core_run, o_core_pc_reset, o_status, o_error}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Upload N=2.
      pulse_start();
      check("start_hdr", {29'd0, o_status}, 32'd1);
      send_word(32'd2);
      send_word(32'h20010005);
      send_word(32'h00000000);
      tick();
      handle_tx(8'hAA, "ack1");
      tick(); tick(); tick();
      check("up_nwr", log_addr.size(), 32'd2);
      if (log_addr.size() == 2) begin
         check("up_w0", {log_addr[0], log_data[0][21:0]}, {10'd0, 22'h010005});
         check("up_w0hi", {22'd0, log_data[0][31:22]}, {22'd0, 10'h080});
         check("up_w1", {22'd0, log_addr[1]}, 32'd1);
         check("up_w1d", log_data[1], 32'h00000000);
      end
      check("up_pcr", pcr_pulses, 32'd1);
      check("up_tx", tx_pulses, 32'd1);
      check("up_run", {28'd0, o_status, o_core_run}, {28'd0, 3'b100, 1'b1});

      // UART arbitration in RUN.
      for (int i = 0; i < 4; i++) apply_vec(run_vecs[i], $sformatf("run_v%0d", i));
      i_tx_ready = 1'b1;
      i_core_tx_enable = 1'b0;
      i_rx_valid = 1'b0;

      // Restart from RUN, upload N=1 over addr 0.
      pulse_start();
      check("rs_run0", {28'd0, o_status, o_core_run}, {28'd0, 3'b001, 1'b0});
      send_word(32'd1);
      send_word(32'hDEADBEEF);
      tick();
      handle_tx(8'hAA, "ack2");
      tick(); tick(); tick();
      check("rs_nwr", log_addr.size(), 32'd3);
      if (log_addr.size() == 3) check("rs_w0", {log_addr[2], log_data[2][21:0]}, {10'd0, 22'h2DBEEF});
      check("rs_pcr", pcr_pulses, 32'd2);
      check("rs_run", {28'd0, o_status, o_core_run}, {28'd0, 3'b100, 1'b1});

      // Start and abort together in RUN: abort wins.
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      i_start = 1'b0;
      i_abort = 1'b0;
      check("sa_idle", {28'd0, o_status, o_core_run}, 32'd0);
      for (int i = 0; i < 2; i++) apply_vec(idle_vecs[i], $sformatf("idle_v%0d", i));
      i_tx_ready = 1'b1;
      i_core_tx_enable = 1'b0;
      i_rx_valid = 1'b0;

      // Header rejects: N=0 and N=1025.
      base = log_addr.size();
      pulse_start();
      send_word(32'd0);
      tick();
      handle_tx(8'h55, "nak0");
      tick();
      check("nak0_st", {28'd0, o_status, o_error}, {28'd0, 3'b000, 1'b1});
      pulse_start();
      check("nak0_clr", {31'd0, o_error}, 32'd0);
      send_word(32'd1025);
      tick();
      handle_tx(8'h55, "nak1");
      tick();
      check("nak1_st", {28'd0, o_status, o_error}, {28'd0, 3'b000, 1'b1});
      check("nak_nwr", log_addr.size(), base);
      pulse_start();
      check("nak1_clr", {31'd0, o_error}, 32'd0);

      // Largest legal header is accepted.
      send_word(32'd1024);
      tick();
      check("max_data", {29'd0, o_status}, 32'd2);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;

      // Abort after 6 data bytes of N=3.
      base = log_addr.size();
      txb = tx_pulses;
      pulse_start();
      send_word(32'd3);
      send_word(32'h11223344);
      send_byte(8'h55);
      send_byte(8'h66);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("ab_st", {28'd0, o_status, o_core_run}, 32'd0);
      for (int i = 0; i < 10; i++) tick();
      check("ab_nwr", log_addr.size(), base + 1);
      if (log_addr.size() == base + 1) begin
         check("ab_w0a", {22'd0, log_addr[base]}, 32'd0);
         check("ab_w0d", log_data[base], 32'h11223344);
      end
      check("ab_notx", tx_pulses, txb);

      // Reset in the middle of a word.
      base = log_addr.size();
      pulse_start();
      send_word(32'd2);
      send_byte(8'h01);
      send_byte(8'h02);
      rst_n = 1'b0;
      #1;
      check("mr_st", {28'd0, o_status, o_core_run}, 32'd0);
      tick();
      rst_n = 1'b1;
      send_byte(8'h03);
      send_byte(8'h04);
      tick(); tick();
      check("mr_nwr", log_addr.size(), base);
      check("mr_idle", {29'd0, o_status}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader_ctrl.md
Name: program_loader_ctrl

Overview:
- Sequences core start-up: accepts a word-count header and a program image over UART and writes it into instruction memory.
- Acknowledges the upload, then releases the core to run.
- Owns the single UART receiver/sender pair and arbitrates it: the loader has it while loading, the core's IN/OUT path has it while running.
- Sits between receiver/sender and the core; drives the instruction-memory write port and the core run/pc-reset controls.

Parameters:
- INST_MEM_WIDTH, 10, instruction memory address width; capacity 2**INST_MEM_WIDTH words.
- ACK_BYTE, 8'hAA, byte sent after a successful load.
- NAK_BYTE, 8'h55, byte sent when the header is rejected.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset
- start  in  1  load request (switch, already debounced), level-sampled
- abort  in  1  abort/halt request, level-sampled
- rx_data  in  8  byte from receiver
- rx_valid  in  1  one-cycle strobe from receiver
- tx_ready  in  1  sender idle
- tx_data  out  8  byte to sender
- tx_enable  out  1  send request to sender
- core_rx_data  out  8  byte to core IN path
- core_rx_valid  out  1  strobe to core IN path
- core_tx_data  in  8  byte from core OUT path
- core_tx_enable  in  1  core send request
- core_tx_ready  out  1  sender idle, as seen by core
- imem_we  out  1  instruction memory write enable
- imem_addr  out  INST_MEM_WIDTH  write address
- imem_wdata  out  32  write data
- core_run  out  1  core may execute
- core_pc_reset  out  1  one-cycle pulse: core pc <= 0
- status  out  3  state code for LEDs
- error  out  1  sticky header-reject flag

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- On reset: every output 0; state IDLE; byte/word counters 0.
- States and status codes: IDLE=000, HDR=001, DATA=010, ACK=011, RUN=100. status is registered and equals the state code.
- Priority each cycle: abort > start > normal progress.
- Abort (any state): next state IDLE; core_run=0; loader tx_enable=0; partial word discarded; words already written stay in memory.
- Start (IDLE, ACK or RUN): next state HDR; core_run=0 next cycle; error cleared; counters cleared. Start in HDR or DATA is ignored.
- HDR: four rx_valid bytes, little-endian, form count N (first byte -> [7:0]).
  - N==0 or N>2**INST_MEM_WIDTH: error=1, send NAK_BYTE, return to IDLE.
  - Otherwise: go to DATA.
- DATA: bytes assembled little-endian into a 32-bit word.
  - The cycle after the 4th byte: imem_we=1 for exactly one cycle, imem_addr = word index (0..N-1), imem_wdata = word.
  - rx bytes are accepted in every cycle, including the imem_we cycle.
  - After word N-1 is written, go to ACK.
- ACK/NAK send handshake:
  - Wait for tx_ready=1, then tx_enable=1 for exactly one cycle with tx_data = ACK_BYTE or NAK_BYTE.
  - Wait for tx_ready=0, then tx_ready=1; send is complete.
  - After ACK: core_pc_reset pulses one cycle, then RUN with core_run=1 from the following cycle.
  - After NAK: go to IDLE.
- RUN arbitration (combinational mux):
  - core_rx_data=rx_data, core_rx_valid=rx_valid.
  - tx_data=core_tx_data, tx_enable=core_tx_enable, core_tx_ready=tx_ready.
  - Outside RUN: core_rx_valid=0, core_tx_ready=0, core_tx_enable ignored.
- rx_valid in IDLE or ACK: byte dropped.
- Word index never wraps; the header check makes index ≤ 2**INST_MEM_WIDTH-1.
- Reset mid-load: immediate IDLE, no further imem writes.

Decomposition:
- Shared package cpuex_pkg:
  - loader_state_t enum.
  - STATUS_* 3-bit codes.
  - ACK_BYTE/NAK_BYTE defaults.
  - UART byte type logic[7:0].
- One natural sub-module: uart_word_assembler. It collects 4 strobed bytes little-endian and emits word + one-cycle word_valid, with a synchronous clear. It is used by both HDR and DATA.

Test Plan:
- Reset then upload N=2, words 32'h20010005, 32'h00000000 -> imem_we pulses at addr 0 then addr 1 with those words; tx byte 8'hAA; core_pc_reset one pulse; status=100; core_run=1.
- Header N=0, then separately N=2**INST_MEM_WIDTH+1 -> no imem_we; tx byte 8'h55; error=1; status=000. A subsequent start clears error.
- Abort asserted after 6 data bytes of N=3 -> exactly one imem_we (addr 0); status=000; core_run=0; no ACK sent.
- In RUN: rx_valid with rx_data=8'h41 -> core_rx_valid=1, core_rx_data=8'h41 same cycle. core_tx_enable with 8'h42 -> tx_enable=1, tx_data=8'h42.
- Start while in RUN -> core_run=0 the next cycle; a new upload of N=1 overwrites addr 0; ACK sent again.
- Start and abort asserted in the same cycle during RUN -> IDLE, not HDR. rx_valid in IDLE -> core_rx_valid stays 0.
